// File: rtl/adder_accum_pkg.sv
// rtl/adder_accum_pkg.sv - shared width helper for the adder tree accumulator
package adder_accum_pkg;

  function automatic int obits(int bits, int len);
    return bits + $clog2(len);
  endfunction

endpackage

// File: rtl/adder_accum_if.sv
// rtl/adder_accum_if.sv - result stream in, frame-sum stream out
interface adder_accum_if
  import adder_accum_pkg::*;
#(
  parameter int BITS = 8,
  parameter int LEN  = 4
);
  localparam int OBITS = obits(BITS, LEN);

  logic             valid;
  logic [BITS-1:0]  i;
  logic [OBITS-1:0] o;
  logic             valid_out;
  logic             ready_out;

  modport master (output valid, i, ready_out, input o, valid_out);
  modport slave  (input valid, i, ready_out, output o, valid_out);
endinterface

// File: rtl/adder_accum_fifo.sv
// rtl/adder_accum_fifo.sv - small pointer/count FIFO with registered head
module adder_accum_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees the slot the push needs, so a full FIFO still accepts.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/adder_accum.sv
// rtl/adder_accum.sv - accumulates LEN adder results per frame into a sum FIFO
module adder_accum
  import adder_accum_pkg::*;
#(
  parameter int  BITS  = 8,
  parameter int  LEN   = 4,
  parameter int  DEPTH = 2,
  localparam int OBITS = obits(BITS, LEN),
  localparam int CW    = $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rst,
  adder_accum_if.slave  bus,
  input  logic          clear,
  output logic          overflow,
  output logic [CW-1:0] frame_cnt
);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic [OBITS-1:0] acc, sum;
  logic [CW-1:0]    cnt;
  logic             last, push, pop, full, empty;

  assign sum       = acc + OBITS'(bus.i);
  assign last      = (cnt == LAST);
  assign push      = bus.valid & ~clear & last;
  assign pop       = bus.valid_out & bus.ready_out;
  assign frame_cnt = cnt;
  assign bus.valid_out = ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.valid) begin
        if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end
      // The tree cannot stall, so a sum with no room is dropped and flagged.
      if (push & full & ~pop) overflow <= 1'b1;
    end
  end

  adder_accum_fifo #(
    .WIDTH (OBITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .data  (sum),
    .pop   (pop),
    .head  (bus.o),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_adder_accum.sv
// tb/tb_adder_accum.sv - directed vector bench for adder_accum
module tb_adder_accum;
  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       overflow;
  logic [1:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  adder_accum_if #(.BITS(8), .LEN(4)) bus ();

  adder_accum #(.BITS(8), .LEN(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clear     (clear),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       clr;
    logic       rdy;
    logic       evo;
    logic [9:0] eo;
    logic       eovf;
    logic [1:0] efc;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mkv(logic v, logic [7:0] d, logic evo, logic [9:0] eo, logic [1:0] efc);
    vec_t r;
    r.v = v; r.d = d; r.clr = 1'b0; r.rdy = 1'b1;
    r.evo = evo; r.eo = eo; r.eovf = 1'b0; r.efc = efc;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic res(input logic [7:0] d);
    bus.valid = 1'b1;
    bus.i     = d;
    tick();
    bus.valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, b, c, d);
    res(a); res(b); res(c); res(d);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    bus.valid = 1'b0; bus.i = '0; bus.ready_out = 1'b1;
    tick(); tick();
    check("reset valid_out", bus.valid_out, 0);
    check("reset o", bus.o, 0);
    check("reset overflow", overflow, 0);
    check("reset frame_cnt", frame_cnt, 0);
    rst = 1'b0;

    // Basic frame, max-value frame, then a back-to-back small frame.
    vecs[0]  = mkv(1, 10,  0, 0,    1);
    vecs[1]  = mkv(1, 20,  0, 0,    2);
    vecs[2]  = mkv(1, 30,  0, 0,    3);
    vecs[3]  = mkv(1, 40,  1, 100,  0);
    vecs[4]  = mkv(0, 0,   0, 0,    0);
    vecs[5]  = mkv(1, 255, 0, 0,    1);
    vecs[6]  = mkv(1, 255, 0, 0,    2);
    vecs[7]  = mkv(1, 255, 0, 0,    3);
    vecs[8]  = mkv(1, 255, 1, 1020, 0);
    vecs[9]  = mkv(1, 1,   0, 0,    1);
    vecs[10] = mkv(1, 1,   0, 0,    2);
    vecs[11] = mkv(1, 1,   0, 0,    3);
    vecs[12] = mkv(1, 1,   1, 4,    0);
    vecs[13] = mkv(0, 0,   0, 0,    0);

    for (int k = 0; k < 14; k++) begin
      bus.valid     = vecs[k].v;
      bus.i         = vecs[k].d;
      clear         = vecs[k].clr;
      bus.ready_out = vecs[k].rdy;
      tick();
      check($sformatf("vec%0d valid_out", k), bus.valid_out, vecs[k].evo);
      if (vecs[k].evo) check($sformatf("vec%0d o", k), bus.o, vecs[k].eo);
      check($sformatf("vec%0d overflow", k), overflow, vecs[k].eovf);
      check($sformatf("vec%0d frame_cnt", k), frame_cnt, vecs[k].efc);
    end
    bus.valid = 1'b0; clear = 1'b0;

    // Backpressure: third sum is dropped.
    bus.ready_out = 1'b0;
    frame(10, 20, 30, 40);
    check("bp first o", bus.o, 100);
    frame(50, 50, 50, 50);
    check("bp two held overflow", overflow, 0);
    frame(75, 75, 75, 75);
    check("bp overflow set", overflow, 1);
    check("bp head kept", bus.o, 100);
    bus.ready_out = 1'b1;
    tick();
    check("bp drain second valid", bus.valid_out, 1);
    check("bp drain second o", bus.o, 200);
    tick();
    check("bp drained empty", bus.valid_out, 0);
    check("bp overflow sticky", overflow, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear resets overflow", overflow, 0);

    // Full FIFO with a push landing on a pop.
    bus.ready_out = 1'b0;
    frame(60, 20, 10, 10);
    frame(100, 50, 25, 25);
    res(1); res(2); res(3);
    bus.ready_out = 1'b1;
    res(4);
    check("pp head after pop", bus.o, 200);
    check("pp overflow", overflow, 0);
    bus.ready_out = 1'b0;
    tick();
    check("pp head stable", bus.o, 200);
    bus.ready_out = 1'b1;
    tick();
    check("pp pushed valid", bus.valid_out, 1);
    check("pp pushed o", bus.o, 10);
    tick();
    check("pp drained", bus.valid_out, 0);

    // Clear mid-frame drops the partial sum and the concurrent input.
    res(5); res(6);
    clear = 1'b1;
    res(7);
    clear = 1'b0;
    check("clr frame_cnt", frame_cnt, 0);
    check("clr overflow", overflow, 0);
    check("clr no push", bus.valid_out, 0);
    res(1); res(2); res(3);
    check("clr frame_cnt 3", frame_cnt, 3);
    res(4);
    check("clr sum valid", bus.valid_out, 1);
    check("clr sum o", bus.o, 10);
    tick();

    // Reset with one queued sum and a partial frame.
    bus.ready_out = 1'b0;
    frame(1, 1, 1, 1);
    res(2); res(2);
    check("rst pre frame_cnt", frame_cnt, 2);
    check("rst pre valid_out", bus.valid_out, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst valid_out", bus.valid_out, 0);
    check("rst frame_cnt", frame_cnt, 0);
    check("rst o", bus.o, 0);
    frame(3, 3, 3, 3);
    check("rst fresh valid", bus.valid_out, 1);
    check("rst fresh o", bus.o, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_accum.md
# adder_accum

Downstream stage of the adder tree: consumes the tree's result stream (`o`/`valid_out` of the top `adder` instance) and accumulates every `LEN` consecutive results into one frame sum. Completed sums go into a small output FIFO. The FIFO presents them on a valid/ready interface to the consumer (stats/DMA writer). The adder tree cannot be stalled, so the block never backpressures its input; it drops sums on FIFO overflow and reports them through a sticky error flag.

## Interface
- `BITS`, 8, width of each incoming adder result (unsigned)
- `LEN`, 4, adder results per frame; legal range 2..256
- `DEPTH`, 2, output FIFO entries; legal range 2..8
- `OBITS`, derived, `BITS + $clog2(LEN)`, frame sum width; must not be overridden
- `clk`  input  1  clock; all state changes on the rising edge
- `rst`  input  1  reset: synchronous, active-high
- `valid`  input  1  adder result valid; one result per cycle when high
- `i`  input  BITS  adder result; sampled only when `valid`=1
- `clear`  input  1  synchronous soft clear: discards the partial frame and clears `overflow`
- `o`  output  OBITS  frame sum at the FIFO head
- `valid_out`  output  1  FIFO not empty
- `ready_out`  input  1  consumer accepts the head when `valid_out & ready_out`
- `overflow`  output  1  sticky flag: at least one completed sum was dropped
- `frame_cnt`  output  $clog2(LEN)  number of results already in the current partial frame

## Operation
- Accumulator `acc` (OBITS) and counter `cnt` (0..LEN-1).
- `valid` with `cnt<LEN-1`: `acc<=acc+i`, `cnt<=cnt+1`.
- `valid` with `cnt==LEN-1`: push `acc+i` to the FIFO; then `acc<=0`, `cnt<=0`. A new frame starts with no bubble.
- Arithmetic is unsigned and zero-extended. OBITS cannot overflow, so there is no wrap or saturation.
- Pop occurs when `valid_out & ready_out`. `o` is stable while `valid_out=1` and `ready_out=0`.
- Push and pop in the same cycle:
  - FIFO full: both take effect and the occupancy is unchanged.
  - FIFO empty: the pushed value appears the next cycle; no fall-through.
- Push while full with no pop: the sum is dropped, the FIFO is unchanged, and `overflow<=1`.
- `clear`:
  - `acc<=0`, `cnt<=0`, `overflow<=0`.
  - FIFO contents are kept and the pop path stays active.
  - `clear` has priority over `valid` in the same cycle: that input is dropped, and a push that would have completed is suppressed.
- `rst` has priority over everything. It empties the FIFO and resets all state.
- Reset values: `o=0`, `valid_out=0`, `overflow=0`, `frame_cnt=0`, `acc=0`.

## Timing
- Latency: last result of a frame accepted at edge t, then `valid_out=1` with the sum after edge t (visible in cycle t+1), when the FIFO was empty.
- Throughput: one result per cycle sustained. One frame sum every `LEN` cycles.
- `overflow` rises in the cycle after the dropped push.
- `rst` mid-frame or mid-drain: the next cycle shows empty/idle, and the partial frame is lost.

## Structure
- Package `adder_accum_pkg` holds `function automatic int obits(int bits, int len)`, so upstream integration computes the same width.
- Sub-module `adder_accum_fifo`:
  - Parameterised `WIDTH`/`DEPTH`.
  - Pointer plus count implementation.
  - Exposes `full`, `empty`, push/pop and the head.
  - Registered head with no fall-through.
- The top level holds `acc`, `cnt`, the overflow logic and the clear/reset priority.

## Test plan
- LEN=4, BITS=8, `ready_out=1`: results 10,20,30,40 on consecutive cycles, so `o=100` and `valid_out` is high for exactly one cycle, the cycle after the 40 is accepted.
- Max values: 255×4 gives `o=1020` (OBITS=10). Follow with 1,1,1,1 back-to-back, giving `o=4` exactly 4 cycles after the first sum.
- Backpressure: `ready_out=0`, three frames with sums 100, 200, 300.
  - `overflow=1` after the third frame completes; FIFO keeps 100 and 200.
  - Then `ready_out=1`: outputs 100, then 200, then `valid_out=0`. `overflow` stays 1.
- FIFO full with simultaneous push/pop: the frame completes in the same cycle as a pop. Order is preserved, `overflow` stays 0, and the occupancy stays at 2.
- `clear` mid-frame: inputs 5, 6, then `clear` together with `valid` carrying 7, then 1,2,3,4.
  - 7 is dropped and the output is `o=10`.
  - `overflow` reads 0 and `frame_cnt` returns to 0.
- `rst` asserted with 1 entry in the FIFO and `cnt=2`. After the reset edge: `valid_out=0`, `frame_cnt=0`, and the next full frame yields the correct fresh sum.
